// File: rtl/serv_dbus_ctrl.sv
// serv_dbus_ctrl: Wishbone classic data-bus master for load/store accesses.
// Optional bus timeout is enabled by defining SERV_DBUS_TIMEOUT_EN.
module serv_dbus_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdat,
    output logic [31:0] o_rdat,
    output logic        o_load,
    output logic        o_done,
    output logic        o_misalign,
    output logic        o_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);
    typedef enum logic [1:0] {IDLE, BUS, DONE, REL} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d, mis_q, mis_d;
    logic        misaligned;
    logic [3:0]  sel_w;
    logic        expired;

    assign misaligned = i_size == 2'b00 ? 1'b0 :
                        i_size == 2'b01 ? i_adr[0] : |i_adr[1:0];
    assign sel_w = i_size == 2'b00 ? 4'b0001 << i_adr[1:0] :
                   i_size == 2'b01 ? (i_adr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

`ifdef SERV_DBUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    // Expire in the BUS cycle whose missing ack would bring the count to all-ones.
    assign expired = cnt_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    assign o_err   = state_q == DONE && err_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE && i_req) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == BUS && !i_wb_ack) begin
            cnt_d = cnt_q + 1'b1;
            err_d = expired;
        end
    end
`else
    assign expired = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (i_req) begin
                mis_d = misaligned;
                if (misaligned) begin
                    state_d = DONE;
                end else begin
                    state_d = BUS;
                    adr_d   = {i_adr[31:2], 2'b00};
                    sel_d   = sel_w;
                    we_d    = i_we;
                    dat_d   = i_wdat;
                end
            end
            BUS: if (i_wb_ack) begin
                state_d = DONE;
                rdat_d  = we_q ? rdat_q : i_wb_rdt;
            end else if (expired) begin
                state_d = DONE;
            end
            DONE: state_d = REL;
            default: state_d = i_req ? REL : IDLE;
        endcase
    end

    assign o_wb_cyc   = state_q == BUS;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = sel_q;
    assign o_wb_we    = we_q;
    assign o_rdat     = rdat_q;
    assign o_done     = state_q == DONE;
    assign o_misalign = o_done && mis_q;
    assign o_load     = o_done && !we_q && !mis_q && !o_err;
endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// tb_serv_dbus_ctrl: directed self-checking bench for serv_dbus_ctrl.
module tb_serv_dbus_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, we, ack, load, done, mis, err, wb_we, cyc;
    logic [31:0] adr, wdat, rdat, wb_adr, wb_dat, rdt;
    logic [1:0]  size;
    logic [3:0]  sel;
    int checks = 0;
    int errors = 0;

    serv_dbus_ctrl #(.TIMEOUT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_adr(adr),
        .i_size(size), .i_wdat(wdat), .o_rdat(rdat), .o_load(load),
        .o_done(done), .o_misalign(mis), .o_err(err), .o_wb_adr(wb_adr),
        .o_wb_dat(wb_dat), .o_wb_sel(sel), .o_wb_we(wb_we), .o_wb_cyc(cyc),
        .i_wb_rdt(rdt), .i_wb_ack(ack)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        req = 1'b1; we = w; adr = a; size = s; wdat = d;
        step();
    endtask

    task automatic finish_access();
        req = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 0; we = 0; adr = 0; size = 0; wdat = 0; rdt = 0; ack = 0;
        step(2);
        checks++;
        if ({cyc, wb_we, load, done, mis, err, sel} !== 10'b0 || wb_adr !== 0 || wb_dat !== 0 || rdat !== 0) begin
            errors++;
            $display("FAIL reset: cyc=%b we=%b load=%b done=%b mis=%b err=%b sel=%b adr=%h dat=%h rdat=%h required all zero",
                     cyc, wb_we, load, done, mis, err, sel, wb_adr, wb_dat, rdat);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word_load();
        start(1'b0, 32'h1004, 2'b10, 32'h0);
        checks++;
        if ({cyc, wb_we, sel} !== 6'b101111 || wb_adr !== 32'h1004) begin
            errors++;
            $display("FAIL word_load_bus: cyc=%b we=%b sel=%b adr=%h required 1 0 1111 00001004", cyc, wb_we, sel, wb_adr);
        end
        step(2);
        checks++;
        if ({cyc, done} !== 2'b10) begin
            errors++;
            $display("FAIL word_load_wait: cyc=%b done=%b required 1 0", cyc, done);
        end
        ack = 1'b1; rdt = 32'hDEADBEEF;
        step();
        ack = 1'b0; rdt = 32'h0;
        checks++;
        if ({cyc, done, load, mis, err} !== 5'b01100 || rdat !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_load_done: cyc=%b done=%b load=%b mis=%b err=%b rdat=%h required 0 1 1 0 0 deadbeef",
                     cyc, done, load, mis, err, rdat);
        end
        step();
        checks++;
        if ({done, load} !== 2'b00) begin
            errors++;
            $display("FAIL word_load_pulse: done=%b load=%b required 0 0", done, load);
        end
        finish_access();
    endtask

    task automatic test_byte_store();
        start(1'b1, 32'h2003, 2'b00, 32'hAB000000);
        checks++;
        if ({cyc, wb_we, sel} !== 6'b111000 || wb_adr !== 32'h2000 || wb_dat !== 32'hAB000000) begin
            errors++;
            $display("FAIL byte_store_bus: cyc=%b we=%b sel=%b adr=%h dat=%h required 1 1 1000 00002000 ab000000",
                     cyc, wb_we, sel, wb_adr, wb_dat);
        end
        ack = 1'b1; rdt = 32'h12345678;
        step();
        ack = 1'b0;
        checks++;
        if ({cyc, done, load} !== 3'b010 || rdat !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL byte_store_done: cyc=%b done=%b load=%b rdat=%h required 0 1 0 deadbeef", cyc, done, load, rdat);
        end
        finish_access();
    endtask

    task automatic test_sel_patterns();
        start(1'b0, 32'h0006, 2'b01, 32'h0);
        checks++;
        if (sel !== 4'b1100 || wb_adr !== 32'h4) begin
            errors++;
            $display("FAIL half_hi_sel: sel=%b adr=%h required 1100 00000004", sel, wb_adr);
        end
        ack = 1'b1; rdt = 32'hCAFE0000;
        step();
        ack = 1'b0;
        finish_access();
        start(1'b0, 32'h0001, 2'b00, 32'h0);
        checks++;
        if (sel !== 4'b0010 || cyc !== 1'b1) begin
            errors++;
            $display("FAIL byte1_sel: sel=%b cyc=%b required 0010 1", sel, cyc);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        finish_access();
    endtask

    task automatic test_misalign();
        start(1'b0, 32'h0001, 2'b01, 32'h0);
        checks++;
        if ({cyc, done, mis, load, err} !== 5'b01100) begin
            errors++;
            $display("FAIL half_misalign: cyc=%b done=%b mis=%b load=%b err=%b required 0 1 1 0 0", cyc, done, mis, load, err);
        end
        step();
        checks++;
        if ({cyc, done, mis} !== 3'b000) begin
            errors++;
            $display("FAIL half_misalign_pulse: cyc=%b done=%b mis=%b required 0 0 0", cyc, done, mis);
        end
        finish_access();
        start(1'b1, 32'h0102, 2'b10, 32'h0);
        checks++;
        if ({cyc, done, mis} !== 3'b011) begin
            errors++;
            $display("FAIL word_misalign: cyc=%b done=%b mis=%b required 0 1 1", cyc, done, mis);
        end
        finish_access();
    endtask

    task automatic test_back_to_back();
        start(1'b0, 32'h0010, 2'b10, 32'h0);
        ack = 1'b1; rdt = 32'h00000055;
        step();
        ack = 1'b0;
        checks++;
        if ({done, load} !== 2'b11 || rdat !== 32'h55) begin
            errors++;
            $display("FAIL b2b_first: done=%b load=%b rdat=%h required 1 1 00000055", done, load, rdat);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({cyc, done} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_held_%0d: cyc=%b done=%b required 0 0", i, cyc, done);
            end
        end
        req = 1'b0;
        step();
        start(1'b0, 32'h0020, 2'b10, 32'h0);
        checks++;
        if (cyc !== 1'b1 || wb_adr !== 32'h20) begin
            errors++;
            $display("FAIL b2b_second: cyc=%b adr=%h required 1 00000020", cyc, wb_adr);
        end
        ack = 1'b1; rdt = 32'h66;
        step();
        ack = 1'b0;
        finish_access();
    endtask

    task automatic test_ack_idle();
        ack = 1'b1; rdt = 32'hFFFFFFFF;
        step(2);
        ack = 1'b0;
        checks++;
        if ({cyc, done, load} !== 3'b000 || rdat !== 32'h66) begin
            errors++;
            $display("FAIL ack_idle: cyc=%b done=%b load=%b rdat=%h required 0 0 0 00000066", cyc, done, load, rdat);
        end
    endtask

    task automatic test_reset_mid_bus();
        logic seen;
        start(1'b0, 32'h3000, 2'b10, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req = 1'b0;
        checks++;
        if ({cyc, done, load} !== 3'b000 || wb_adr !== 0) begin
            errors++;
            $display("FAIL reset_mid_bus: cyc=%b done=%b load=%b adr=%h required 0 0 0 00000000", cyc, done, load, wb_adr);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= done | load | cyc;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_bus_quiet: activity=%b required 0", seen);
        end
        start(1'b0, 32'h3004, 2'b10, 32'h0);
        ack = 1'b1; rdt = 32'h0BADF00D;
        step();
        ack = 1'b0;
        checks++;
        if ({done, load} !== 2'b11 || rdat !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL reset_mid_bus_next: done=%b load=%b rdat=%h required 1 1 0badf00d", done, load, rdat);
        end
        finish_access();
    endtask

`ifdef SERV_DBUS_TIMEOUT_EN
    task automatic test_timeout();
        logic stay;
        start(1'b0, 32'h4000, 2'b10, 32'h0);
        stay = 1'b1;
        for (int i = 0; i < 14; i++) begin
            stay &= cyc;
            step();
        end
        checks++;
        if (stay !== 1'b1 || cyc !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: cyc=%b stayed=%b required 1 1", cyc, stay);
        end
        step();
        checks++;
        if ({cyc, done, err, load} !== 4'b0110) begin
            errors++;
            $display("FAIL timeout_expire: cyc=%b done=%b err=%b load=%b required 0 1 1 0", cyc, done, err, load);
        end
        finish_access();
        start(1'b0, 32'h4004, 2'b10, 32'h0);
        step(14);
        ack = 1'b1; rdt = 32'h15151515;
        step();
        ack = 1'b0;
        checks++;
        if ({cyc, done, err, load} !== 4'b0101 || rdat !== 32'h15151515) begin
            errors++;
            $display("FAIL timeout_ack_wins: cyc=%b done=%b err=%b load=%b rdat=%h required 0 1 0 1 15151515",
                     cyc, done, err, load, rdat);
        end
        finish_access();
    endtask
`else
    task automatic test_timeout();
        start(1'b0, 32'h4000, 2'b10, 32'h0);
        step(20);
        checks++;
        if ({cyc, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL no_timeout_wait: cyc=%b done=%b err=%b required 1 0 0", cyc, done, err);
        end
        ack = 1'b1; rdt = 32'h15151515;
        step();
        ack = 1'b0;
        checks++;
        if ({done, err, load} !== 3'b101 || rdat !== 32'h15151515) begin
            errors++;
            $display("FAIL no_timeout_done: done=%b err=%b load=%b rdat=%h required 1 0 1 15151515", done, err, load, rdat);
        end
        finish_access();
    endtask
`endif

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_sel_patterns();
        test_misalign();
        test_back_to_back();
        test_ack_idle();
        test_reset_mid_bus();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
